// File: rtl/iis_sample_fifo.sv
// -----------------------------------------------------------------------------
// iis_sample_fifo
//
// Stereo sample buffer between the I2S receive port and the ADSP core.
// Each write_en pulse captures one {left, right} 32-bit pair. The head pair is
// presented first-word-fall-through on a valid/ready handshake. Output is held
// off (PRIME state) until the occupancy reaches PRIME_LEVEL. Sticky overflow
// and underflow flags are reported to the register map.
//
// Optional build macro: IIS_FIFO_ZERO_FILL_EN
//   When defined, RUN keeps adsp_valid high even when empty; an empty head
//   reads as zero, a transfer while empty flags underflow and stays in RUN.
//
// Ports:
//   sck                  clock, all logic on the rising edge
//   rst_n                asynchronous active-low reset
//   write_en             one-cycle pulse, new pair on iis_adsp_*_data
//   iis_adsp_left_data   left sample from the I2S port
//   iis_adsp_right_data  right sample from the I2S port
//   regmap_fifo_clr      synchronous flush (pointers, level, state)
//   regmap_flag_clr      clears the sticky flags
//   adsp_ready           ADSP accepts the head pair this cycle
//   adsp_valid           head pair available
//   adsp_left_data       head left sample
//   adsp_right_data      head right sample
//   fifo_level           current occupancy, 0..2^DEPTH_LOG2
//   fifo_ovf             sticky overflow flag
//   fifo_udf             sticky underflow flag
// -----------------------------------------------------------------------------
module iis_sample_fifo #(
   parameter int DEPTH_LOG2  = 3,
   parameter int PRIME_LEVEL = 4
) (
   input  logic                  sck,
   input  logic                  rst_n,
   input  logic                  write_en,
   input  logic [31:0]           iis_adsp_left_data,
   input  logic [31:0]           iis_adsp_right_data,
   input  logic                  regmap_fifo_clr,
   input  logic                  regmap_flag_clr,
   input  logic                  adsp_ready,
   output logic                  adsp_valid,
   output logic [31:0]           adsp_left_data,
   output logic [31:0]           adsp_right_data,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  fifo_ovf,
   output logic                  fifo_udf
);

   localparam int                DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] PRIME_LVL = (DEPTH_LOG2+1)'(PRIME_LEVEL);

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Storage and state
   logic [63:0]           mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   state_t                state_q, state_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;

   // Datapath decode
   logic full;
   logic empty;
   logic run;
   logic transfer;
   logic rd_adv;
   logic wr_acc;
   logic ovf_event;
   logic udf_event;

   assign full     = (level_q == FULL_LVL);
   assign empty    = (level_q == '0);
   assign run      = (state_q == ST_RUN);
   assign transfer = adsp_valid && adsp_ready;

   // A transfer only consumes data when something is stored; in zero-fill
   // mode the handshake can complete on an empty FIFO without moving pointers.
   assign rd_adv    = transfer && !empty;
   assign udf_event = run && adsp_ready && empty;

   // A flush discards a coincident write, so it is neither stored nor counted
   // as an overflow. A read in the same cycle frees a slot on a full FIFO.
   assign wr_acc    = write_en && !regmap_fifo_clr && (!full || rd_adv);
   assign ovf_event = write_en && !regmap_fifo_clr && full && !rd_adv;

   // Sample storage: no reset needed, the pointers and level define validity.
   always_ff @(posedge sck) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= {iis_adsp_left_data, iis_adsp_right_data};
      end
   end

   // Pointer, level and flag next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (regmap_fifo_clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
         end
         if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
         end
         level_d = level_q + (DEPTH_LOG2+1)'(wr_acc) - (DEPTH_LOG2+1)'(rd_adv);
      end
   end

   // A new event in the same cycle as a flag clear keeps the flag set.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (regmap_flag_clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (ovf_event) begin
         ovf_d = 1'b1;
      end
      if (udf_event) begin
         udf_d = 1'b1;
      end
   end

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // FSM: state register
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_PRIME;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state. The priming threshold uses the registered level, so
   // adsp_valid rises the cycle after the threshold is reached.
   always_comb begin
      state_d = state_q;
      if (regmap_fifo_clr) begin
         state_d = ST_PRIME;
      end else begin
         case (state_q)
            ST_PRIME: begin
               if (level_q >= PRIME_LVL) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
`ifdef IIS_FIFO_ZERO_FILL_EN
               state_d = ST_RUN;
`else
               if (udf_event) begin
                  state_d = ST_PRIME;
               end
`endif
            end
            default: state_d = ST_PRIME;
         endcase
      end
   end

   // FSM: outputs. Head data is gated to zero whenever no stored pair is
   // being presented, which also gives the zero-fill value when empty.
   logic head_live;
   assign head_live = run && !empty;

   always_comb begin
`ifdef IIS_FIFO_ZERO_FILL_EN
      adsp_valid = run;
`else
      adsp_valid = head_live;
`endif
      adsp_left_data  = 32'h0;
      adsp_right_data = 32'h0;
      if (head_live) begin
         adsp_left_data  = mem_q[rd_ptr_q][63:32];
         adsp_right_data = mem_q[rd_ptr_q][31:0];
      end
   end

   assign fifo_level = level_q;
   assign fifo_ovf   = ovf_q;
   assign fifo_udf   = udf_q;

endmodule

// File: tb/tb_iis_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_iis_sample_fifo
//
// Scoreboard bench for iis_sample_fifo: every accepted pair is queued when
// driven and compared against the head when the DUT completes a transfer.
// A small occupancy/state/flag model supplies the expected control outputs.
// -----------------------------------------------------------------------------
module tb_iis_sample_fifo;

`ifdef IIS_FIFO_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif
   localparam int DEPTH = 8;
   localparam int PRIME = 4;

   logic        sck = 1'b0;
   logic        rst_n;
   logic        write_en;
   logic [31:0] iis_adsp_left_data;
   logic [31:0] iis_adsp_right_data;
   logic        regmap_fifo_clr;
   logic        regmap_flag_clr;
   logic        adsp_ready;
   logic        adsp_valid;
   logic [31:0] adsp_left_data;
   logic [31:0] adsp_right_data;
   logic [3:0]  fifo_level;
   logic        fifo_ovf;
   logic        fifo_udf;

   iis_sample_fifo #(
      .DEPTH_LOG2  (3),
      .PRIME_LEVEL (PRIME)
   ) dut (
      .sck                 (sck),
      .rst_n               (rst_n),
      .write_en            (write_en),
      .iis_adsp_left_data  (iis_adsp_left_data),
      .iis_adsp_right_data (iis_adsp_right_data),
      .regmap_fifo_clr     (regmap_fifo_clr),
      .regmap_flag_clr     (regmap_flag_clr),
      .adsp_ready          (adsp_ready),
      .adsp_valid          (adsp_valid),
      .adsp_left_data      (adsp_left_data),
      .adsp_right_data     (adsp_right_data),
      .fifo_level          (fifo_level),
      .fifo_ovf            (fifo_ovf),
      .fifo_udf            (fifo_udf)
   );

   always #5 sck = ~sck;

   int total = 0;
   int bad   = 0;

   // Reference model
   logic [63:0] sb [$];
   int          m_level = 0;
   bit          m_run   = 1'b0;
   bit          m_ovf   = 1'b0;
   bit          m_udf   = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lval(input int n);
      return 32'h1000_0001 + 32'(n);
   endfunction

   function automatic logic [31:0] rval(input int n);
      return 32'h2000_0001 + 32'(n);
   endfunction

   // One clock cycle: drive inputs after the falling edge, check the outputs
   // registered by the previous rising edge, then advance the model.
   task automatic step(input logic we, input logic [31:0] l, input logic [31:0] r,
                       input logic rdy, input logic fclr, input logic flclr);
      bit          exp_valid;
      bit          xfer;
      bit          pop;
      bit          acc;
      bit          ovf_ev;
      bit          udf_ev;
      int          old_level;
      logic [63:0] head_exp;
      write_en            = we;
      iis_adsp_left_data  = l;
      iis_adsp_right_data = r;
      adsp_ready          = rdy;
      regmap_fifo_clr     = fclr;
      regmap_flag_clr     = flclr;
      #1;
      exp_valid = m_run && (ZF || m_level != 0);
      check("level", 64'(fifo_level), 64'(m_level));
      check("valid", 64'(adsp_valid), 64'(exp_valid));
      check("ovf",   64'(fifo_ovf),   64'(m_ovf));
      check("udf",   64'(fifo_udf),   64'(m_udf));
      if (exp_valid) begin
         head_exp = (m_level != 0) ? sb[0] : 64'h0;
         check("head", {adsp_left_data, adsp_right_data}, head_exp);
      end
      xfer   = exp_valid && rdy;
      pop    = xfer && (m_level != 0);
      udf_ev = m_run && rdy && (m_level == 0);
      acc    = we && !fclr && (m_level < DEPTH || pop);
      ovf_ev = we && !fclr && (m_level == DEPTH) && !pop;
      if (xfer) begin
         $display("xfer L=%h R=%h level=%0d", adsp_left_data, adsp_right_data, m_level);
      end
      if (pop) begin
         void'(sb.pop_front());
      end
      if (acc) begin
         sb.push_back({l, r});
      end
      @(posedge sck);
      old_level = m_level;
      if (fclr) begin
         m_level = 0;
         sb.delete();
         m_run = 1'b0;
      end else begin
         m_level = m_level + int'(acc) - int'(pop);
         if (!m_run) begin
            m_run = (old_level >= PRIME);
         end else if (udf_ev && !ZF) begin
            m_run = 1'b0;
         end
      end
      m_ovf = ovf_ev || (m_ovf && !flclr);
      m_udf = udf_ev || (m_udf && !flclr);
      @(negedge sck);
   endtask

   task automatic wr(input int n, input logic rdy);
      step(1'b1, lval(n), rval(n), rdy, 1'b0, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_level"}, 64'(fifo_level), 64'h0);
      check({tag, "_valid"}, 64'(adsp_valid), 64'h0);
      check({tag, "_left"},  64'(adsp_left_data), 64'h0);
      check({tag, "_right"}, 64'(adsp_right_data), 64'h0);
      check({tag, "_ovf"},   64'(fifo_ovf), 64'h0);
      check({tag, "_udf"},   64'(fifo_udf), 64'h0);
   endtask

   initial begin
      rst_n               = 1'b0;
      write_en            = 1'b0;
      iis_adsp_left_data  = 32'h0;
      iis_adsp_right_data = 32'h0;
      regmap_fifo_clr     = 1'b0;
      regmap_flag_clr     = 1'b0;
      adsp_ready          = 1'b0;
      repeat (2) @(negedge sck);
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // Priming: valid stays low until level 4, then rises one cycle later
      for (int n = 0; n < 4; n++) wr(n, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // Ordered drain
      for (int n = 0; n < 4; n++) idle(1'b1);
      idle(1'b0);

      // Overflow on a full FIFO: dropped pair must never be read
      for (int n = 0; n < 8; n++) wr(16 + n, 1'b0);
      step(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

      // Full with simultaneous read: accepted, no overflow, 8th read
      step(1'b1, 32'hCAFE_0001, 32'hCAFE_0002, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 8; n++) idle(1'b1);
      idle(1'b0);

      // Underflow on an empty FIFO in RUN, then re-prime
      idle(1'b1);
      idle(1'b0);
      for (int n = 0; n < 4; n++) wr(40 + n, 1'b0);
      idle(1'b0);
      idle(1'b0);
      for (int n = 0; n < 4; n++) idle(1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

      // Flag clear coincident with an overflow event
      for (int n = 0; n < 8; n++) wr(60 + n, 1'b0);
      idle(1'b0);
      step(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
      idle(1'b0);

      // Flush at level 5; the coincident write is discarded
      for (int n = 0; n < 3; n++) idle(1'b1);
      step(1'b1, 32'hBAD0_0001, 32'hBAD0_0002, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // Reset mid-burst: outputs clear asynchronously
      for (int n = 0; n < 6; n++) wr(80 + n, 1'b0);
      idle(1'b0);
      idle(1'b0);
      write_en = 1'b1;
      iis_adsp_left_data  = lval(99);
      iis_adsp_right_data = rval(99);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      sb.delete();
      m_level = 0;
      m_run   = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      write_en = 1'b0;
      @(negedge sck);
      rst_n = 1'b1;

      // Normal operation after reset
      for (int n = 0; n < 4; n++) wr(120 + n, 1'b0);
      idle(1'b0);
      for (int n = 0; n < 4; n++) idle(1'b1);
      idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iis_sample_fifo.md
Name: iis_sample_fifo

Overview:
- Stereo sample buffer directly downstream of the I2S receive port.
- Captures each (left, right) 32-bit pair on the port's one-cycle write_en pulse. Presents samples to the ADSP core through a valid/ready handshake.
- Holds output off until a priming level is reached, and reports overflow and underflow to the register map.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO depth in stereo pairs (depth = 8)
PRIME_LEVEL, 4, occupancy required before output is released; 1..2^DEPTH_LOG2

Ports:
sck  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
write_en  input  1  one-cycle pulse: new sample pair on iis_adsp_*_data
iis_adsp_left_data  input  32  left sample from the I2S port
iis_adsp_right_data  input  32  right sample from the I2S port
regmap_fifo_clr  input  1  synchronous flush (level pulse, active high)
regmap_flag_clr  input  1  clears sticky flags
adsp_ready  input  1  ADSP accepts head sample this cycle
adsp_valid  output  1  head sample available
adsp_left_data  output  32  head left sample
adsp_right_data  output  32  head right sample
fifo_level  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
fifo_ovf  output  1  sticky overflow flag
fifo_udf  output  1  sticky underflow flag

Behaviour:
- Clock and reset: one clock, sck. Asynchronous active-low reset rst_n.
- Reset state: pointers 0, fifo_level 0, state PRIME, adsp_valid 0, fifo_ovf 0, fifo_udf 0.
- Storage: register array of 2^DEPTH_LOG2 entries x 64 bits, {left, right}.
- Pointers: DEPTH_LOG2-bit write and read pointers that wrap naturally. full = (level == 2^DEPTH_LOG2); empty = (level == 0).
- Head data: adsp_left_data / adsp_right_data = entry at the read pointer (first-word fall-through, combinational from the array). Undefined content is allowed when adsp_valid = 0.
- Write: write_en && !full stores the pair and advances the write pointer; visible at the head on the next cycle at the earliest.
- Write while full: write_en && full && !transfer drops the sample and sets fifo_ovf. Stored data are unchanged.
- Write while full with a read: write_en && full && transfer accepts both; level stays at full; no overflow.
- Transfer: adsp_valid && adsp_ready advances the read pointer.
- Level: level += write accepted, −= transfer; simultaneous write and transfer leave it unchanged.
- State machine (2 states):
  - PRIME: adsp_valid = 0. Moves to RUN when the registered fifo_level >= PRIME_LEVEL. adsp_valid rises on the cycle after the threshold is reached.
  - RUN: adsp_valid = !empty.
  - RUN underflow: adsp_ready && empty sets fifo_udf and returns to PRIME. No transfer occurs in that cycle.
- regmap_fifo_clr: next cycle pointers 0, level 0, state PRIME. A write_en in the same cycle is discarded. Flags are unaffected.
- regmap_flag_clr: clears both flags next cycle. A new ovf/udf event in the same cycle wins (flag stays 1).
- Reset mid-operation: all state returns to the reset values immediately; no partial sample survives.

Optional Feature:
Macro: IIS_FIFO_ZERO_FILL_EN
- Defined:
  - In RUN, adsp_valid is held 1 regardless of occupancy.
  - When empty, adsp_left_data and adsp_right_data are forced to 32'h0. A transfer while empty sets fifo_udf, does not move pointers, and the state stays RUN (no re-prime).
  - PRIME behaviour is unchanged.
- Not defined: behaviour exactly as in the Behaviour section.

Test Plan:
- Priming: after reset write 4 pairs (L=32'h1000_0001+n, R=32'h2000_0001+n), adsp_ready=0 -> adsp_valid stays 0 until fifo_level=4, rises one cycle later; head L=32'h1000_0001.
- Ordering: drain with adsp_ready=1 -> 4 transfers in order n=0..3; fifo_level 4→0; adsp_valid falls after the last transfer; no flags set.
- Overflow: fill 8 pairs with adsp_ready=0, then write_en with L=32'hDEAD_BEEF -> fifo_ovf=1, level stays 8, drained data never contain 32'hDEAD_BEEF.
- Full with simultaneous read: full FIFO, write_en and adsp_ready in the same cycle -> level stays 8, fifo_ovf stays 0, new pair appears as the 8th read.
- Underflow: in RUN with empty FIFO, adsp_ready=1 -> fifo_udf=1, state PRIME, adsp_valid=0 until 4 new pairs. With IIS_FIFO_ZERO_FILL_EN: adsp_valid=1, data 0, fifo_udf=1, still RUN.
- Clear and reset: regmap_flag_clr coincident with an ovf event -> fifo_ovf stays 1; regmap_fifo_clr at level 5 -> level 0, adsp_valid 0; rst_n low mid-burst -> all outputs 0 asynchronously.
